// File: rtl/mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_sequencer_if
// Description : Operand, accumulator and status bundle for mac_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_sequencer_if;
    logic        start;
    logic [5:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [17:0] acc_q;
    logic [17:0] acc_d;
    logic        acc_clr;
    logic        busy;
    logic [17:0] result;
    logic        result_valid;
    logic        sat_flag;

    // Master side issues jobs, supplies operands and owns the accumulator register.
    modport master (
        output start, len, in_valid, in_a, in_b, acc_q,
        input  in_ready, acc_d, acc_clr, busy, result, result_valid, sat_flag
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, acc_q,
        output in_ready, acc_d, acc_clr, busy, result, result_valid, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_sequencer
// Description : Sequences one signed dot-product job through an external
//               18-bit saturating accumulator register.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_sequencer (
    input  wire logic       clk,
    input  wire logic       reset,
    mac_sequencer_if.slave  bus
);

    localparam logic [2:0]  c_IDLE    = 3'd0;
    localparam logic [2:0]  c_CLEAR   = 3'd1;
    localparam logic [2:0]  c_RUN     = 3'd2;
    localparam logic [2:0]  c_DRAIN   = 3'd3;
    localparam logic [2:0]  c_DONE    = 3'd4;

    localparam logic [17:0] c_SAT_MAX = 18'h1FFFF;
    localparam logic [17:0] c_SAT_MIN = 18'h20000;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [5:0]  r_cnt;
    logic [5:0]  r_len;
    logic [15:0] r_prod;
    logic        r_prod_v;
    logic [17:0] r_result;
    logic        r_result_valid;
    logic        r_sat_flag;

    logic        w_in_ready;
    logic        w_busy;
    logic        w_clear;
    logic        w_start_acc;
    logic        w_xfer;
    logic [15:0] w_a_ext;
    logic [15:0] w_b_ext;
    logic [15:0] w_prod;
    logic [18:0] w_sum;
    logic        w_ovf;
    logic [17:0] w_sat_sum;
    logic [17:0] w_acc_d;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b1;
        w_clear      = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next_state = c_CLEAR;
                end
            end
            c_CLEAR: begin
                w_clear      = 1'b1;
                w_next_state = (r_len != 6'd0) ? c_RUN : c_DRAIN;
            end
            c_RUN: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (r_cnt == 6'd1)) begin
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                w_next_state = c_DONE;
            end
            c_DONE: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = c_IDLE;
            end
        endcase
    end

    assign w_start_acc = (r_state == c_IDLE) && bus.start;
    assign w_xfer      = w_in_ready && bus.in_valid;

    // Low 16 bits of the sign-extended product equal the signed 8x8 product.
    assign w_a_ext = {{8{bus.in_a[7]}}, bus.in_a};
    assign w_b_ext = {{8{bus.in_b[7]}}, bus.in_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // One guard bit is enough: |prod| <= 2^14 and the accumulator is 18 bits.
    assign w_sum     = {bus.acc_q[17], bus.acc_q} + {{3{r_prod[15]}}, r_prod};
    assign w_ovf     = w_sum[18] ^ w_sum[17];
    assign w_sat_sum = w_ovf ? (w_sum[18] ? c_SAT_MIN : c_SAT_MAX) : w_sum[17:0];

    always_comb begin
        w_acc_d = bus.acc_q;
        if (!reset || w_clear) begin
            w_acc_d = 18'd0;
        end else if (r_prod_v) begin
            w_acc_d = w_sat_sum;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt          <= 6'd0;
            r_len          <= 6'd0;
            r_prod         <= 16'd0;
            r_prod_v       <= 1'b0;
            r_result       <= 18'd0;
            r_result_valid <= 1'b0;
            r_sat_flag     <= 1'b0;
        end else begin
            r_prod_v       <= w_xfer;
            r_result_valid <= (r_state == c_DONE);

            if (w_start_acc) begin
                r_len <= bus.len;
                r_cnt <= bus.len;
            end else if (w_xfer) begin
                r_cnt <= r_cnt - 6'd1;
            end

            if (w_xfer) begin
                r_prod <= w_prod;
            end

            if (r_state == c_DONE) begin
                r_result <= bus.acc_q;
            end

            // A fresh job clears the sticky flag even if a clamp is pending.
            if (w_start_acc) begin
                r_sat_flag <= 1'b0;
            end else if (r_prod_v && w_ovf) begin
                r_sat_flag <= 1'b1;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.busy         = w_busy;
    assign bus.acc_clr      = w_clear | ~reset;
    assign bus.acc_d        = w_acc_d;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.sat_flag     = r_sat_flag;

endmodule
`default_nettype wire
